// File: rtl/systolic_scheduler.sv
// Sequencer for an N x N weight-stationary systolic array: weight load, skewed vector stream, result valids.
// Optional SCHED_WEIGHT_REUSE_EN adds a reuse_weights input that skips the weight load phase.
module systolic_scheduler #(
    parameter int MATRIX_SIZE = 2,
    parameter int VEC_W       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [VEC_W-1:0]             num_vectors,
`ifdef SCHED_WEIGHT_REUSE_EN
    input  logic                         reuse_weights,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [MATRIX_SIZE-1:0]       load_weight,
    output logic [MATRIX_SIZE-1:0]       enable_mult,
    output logic                         w_rd_en,
    output logic [VEC_W-1:0]             w_rd_addr,
    output logic [MATRIX_SIZE-1:0]       d_rd_en,
    output logic [MATRIX_SIZE*VEC_W-1:0] d_rd_addr,
    output logic [MATRIX_SIZE-1:0]       out_valid,
    output logic [MATRIX_SIZE*VEC_W-1:0] out_addr
);

    localparam int N  = MATRIX_SIZE;
    localparam int CW = VEC_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD_W = 2'b01,
        STREAM = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t               state_r, nxt_state_s;
    logic [CW-1:0]        cnt_r, nxt_cnt_s, last_t_s, nv_ext_s;
    logic [VEC_W-1:0]     nv_r, nxt_nv_s;
    logic                 skip_load_s;
    logic                 busy_s, done_s, w_rd_en_s;
    logic [N-1:0]         load_weight_s, enable_mult_s, out_valid_s;
    logic [VEC_W-1:0]     w_rd_addr_s;
    logic [N*VEC_W-1:0]   d_rd_addr_s, out_addr_s;

`ifdef SCHED_WEIGHT_REUSE_EN
    assign skip_load_s = reuse_weights;
`else
    assign skip_load_s = 1'b0;
`endif

    // Last stream count: the final column drains nv + 2N - 2 cycles after the first row starts.
    assign last_t_s = {1'b0, nv_r} + CW'(2 * N - 2);

    // Next-state, phase counter and latched vector count.
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        nxt_nv_s    = nv_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    nxt_nv_s  = num_vectors;
                    nxt_cnt_s = '0;
                    if (skip_load_s) begin
                        nxt_state_s = (num_vectors == '0) ? DONE : STREAM;
                    end else begin
                        nxt_state_s = LOAD_W;
                    end
                end else begin
                    nxt_cnt_s = '0;
                end
            end
            LOAD_W: begin
                if (cnt_r == CW'(N - 1)) begin
                    nxt_cnt_s   = '0;
                    nxt_state_s = (nv_r == '0) ? DONE : STREAM;
                end else begin
                    nxt_cnt_s = cnt_r + 1'b1;
                end
            end
            STREAM: begin
                if (cnt_r == last_t_s) begin
                    nxt_cnt_s   = '0;
                    nxt_state_s = DONE;
                end else begin
                    nxt_cnt_s = cnt_r + 1'b1;
                end
            end
            DONE: begin
                nxt_cnt_s   = '0;
                nxt_state_s = IDLE;
            end
            default: begin
                nxt_cnt_s   = '0;
                nxt_state_s = IDLE;
            end
        endcase
    end

    // Decode the outputs for the state/count being entered so the registered outputs are Moore-aligned.
    always_comb begin
        busy_s        = (nxt_state_s != IDLE);
        done_s        = (nxt_state_s == DONE);
        load_weight_s = '0;
        w_rd_en_s     = 1'b0;
        w_rd_addr_s   = '0;
        enable_mult_s = '0;
        d_rd_addr_s   = '0;
        out_valid_s   = '0;
        out_addr_s    = '0;
        nv_ext_s      = {1'b0, nxt_nv_s};
        if (nxt_state_s == LOAD_W) begin
            load_weight_s = '1;
            w_rd_en_s     = 1'b1;
            w_rd_addr_s   = VEC_W'(N - 1) - nxt_cnt_s[VEC_W-1:0];
        end else if (nxt_state_s == STREAM) begin
            for (int r = 0; r < N; r++) begin
                if ((nxt_cnt_s >= CW'(r)) && (nxt_cnt_s < CW'(r) + nv_ext_s)) begin
                    enable_mult_s[r]               = 1'b1;
                    d_rd_addr_s[r*VEC_W +: VEC_W]  = nxt_cnt_s[VEC_W-1:0] - VEC_W'(r);
                end else begin
                    enable_mult_s[r] = 1'b0;
                end
            end
            for (int c = 0; c < N; c++) begin
                if ((nxt_cnt_s >= CW'(N + c)) && (nxt_cnt_s < CW'(N + c) + nv_ext_s)) begin
                    out_valid_s[c]                = 1'b1;
                    out_addr_s[c*VEC_W +: VEC_W]  = nxt_cnt_s[VEC_W-1:0] - VEC_W'(N + c);
                end else begin
                    out_valid_s[c] = 1'b0;
                end
            end
        end else begin
            load_weight_s = '0;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            nv_r        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_weight <= '0;
            enable_mult <= '0;
            w_rd_en     <= 1'b0;
            w_rd_addr   <= '0;
            d_rd_en     <= '0;
            d_rd_addr   <= '0;
            out_valid   <= '0;
            out_addr    <= '0;
        end else begin
            state_r     <= nxt_state_s;
            cnt_r       <= nxt_cnt_s;
            nv_r        <= nxt_nv_s;
            busy        <= busy_s;
            done        <= done_s;
            load_weight <= load_weight_s;
            enable_mult <= enable_mult_s;
            w_rd_en     <= w_rd_en_s;
            w_rd_addr   <= w_rd_addr_s;
            d_rd_en     <= enable_mult_s;
            d_rd_addr   <= d_rd_addr_s;
            out_valid   <= out_valid_s;
            out_addr    <= out_addr_s;
        end
    end

endmodule
